irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_pkg.sv | 11 +
 rtl/priority_encoder.sv | 23 ++
 rtl/irq_controller.sv | 93 +++++++++
 tb/tb_irq_controller.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: FSM state type and default width.
package irq_pkg;

    localparam int unsigned IRQ_NUM_INPUTS_DEF = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ISSUED = 1'b1
    } irq_state_e;

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports the highest set input index.
module priority_encoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]         inputs,
    output logic [$clog2(WIDTH)-1:0] result,
    output logic                     valid
);

    localparam int unsigned IDW = $clog2(WIDTH);

    always_comb begin
        result = '0;
        // Ascending scan so the last (highest) set bit overwrites earlier ones.
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (inputs[i]) begin
                result = i[IDW-1:0];
            end
        end
        valid = |inputs;
    end

endmodule

// File: rtl/irq_controller.sv
// Edge-triggered interrupt controller with maskable pending bits and a single issue/ack slot.
module irq_controller
    import irq_pkg::*;
#(
    parameter int unsigned NUM_INPUTS = IRQ_NUM_INPUTS_DEF
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_INPUTS-1:0]         req,
    input  logic                          mask_wr,
    input  logic [NUM_INPUTS-1:0]         mask_in,
    input  logic                          ack,
    output logic                          irq_valid,
    output logic [$clog2(NUM_INPUTS)-1:0] irq_id,
    output logic [NUM_INPUTS-1:0]         pending
);

    localparam int unsigned IDW = $clog2(NUM_INPUTS);

    irq_state_e              state_q, state_d;
    logic [NUM_INPUTS-1:0]   req_prev_q;
    logic [NUM_INPUTS-1:0]   mask_q, mask_d;
    logic [NUM_INPUTS-1:0]   pending_q, pending_d;
    logic                    valid_q, valid_d;
    logic [IDW-1:0]          id_q, id_d;

    logic [NUM_INPUTS-1:0]   edges;
    logic [NUM_INPUTS-1:0]   clr;
    logic [NUM_INPUTS-1:0]   candidates;
    logic [IDW-1:0]          sel_id;
    logic                    cand_any;

    assign candidates = pending_q & ~mask_q;

    priority_encoder #(
        .WIDTH (NUM_INPUTS)
    ) u_prio (
        .inputs (candidates),
        .result (sel_id),
        .valid  (cand_any)
    );

    always_comb begin
        edges   = req & ~req_prev_q;
        clr     = '0;
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        case (state_q)
            IDLE: begin
                if (cand_any) begin
                    state_d = ISSUED;
                    valid_d = 1'b1;
                    id_d    = sel_id;
                end
            end
            ISSUED: begin
                if (ack) begin
                    clr[id_q] = 1'b1;
                    state_d   = IDLE;
                    valid_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Set after clear so a coinciding new edge keeps the bit pending.
        pending_d = (pending_q & ~clr) | edges;
        mask_d    = mask_wr ? mask_in : mask_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_prev_q <= '0;
            mask_q     <= '1;
            pending_q  <= '0;
            valid_q    <= 1'b0;
            id_q       <= '0;
        end else begin
            state_q    <= state_d;
            req_prev_q <= req;
            mask_q     <= mask_d;
            pending_q  <= pending_d;
            valid_q    <= valid_d;
            id_q       <= id_d;
        end
    end

    assign irq_valid = valid_q;
    assign irq_id    = id_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus random traffic against a reference model.
module tb_irq_controller;

    localparam int unsigned N   = 8;
    localparam int unsigned IDW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic           mask_wr;
    logic [N-1:0]   mask_in;
    logic           ack;
    logic           irq_valid;
    logic [IDW-1:0] irq_id;
    logic [N-1:0]   pending;

    int checks = 0;
    int errors = 0;

    // Reference model state, kept as plain integers.
    int m_prev, m_mask, m_pend, m_valid, m_id;

    irq_controller #(
        .NUM_INPUTS (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mask_wr   (mask_wr),
        .mask_in   (mask_in),
        .ack       (ack),
        .irq_valid (irq_valid),
        .irq_id    (irq_id),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int highest(input int v);
        int r = 0;
        while (v > 1) begin
            v = v >> 1;
            r++;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_prev = 0; m_mask = 'hFF; m_pend = 0; m_valid = 0; m_id = 0;
    endtask

    // One clock of the reference behaviour, using the inputs sampled at the edge.
    task automatic model_clock();
        int edges, nxt, cand;
        edges = int'(req) & ~m_prev & 'hFF;
        nxt   = m_pend;
        if (m_valid == 1) begin
            if (ack) begin
                nxt     = nxt & ~(1 << m_id);
                m_valid = 0;
            end
        end else begin
            cand = m_pend & ~m_mask & 'hFF;
            if (cand != 0) begin
                m_valid = 1;
                m_id    = highest(cand);
            end
        end
        m_pend = nxt | edges;
        if (mask_wr) m_mask = int'(mask_in);
        m_prev = int'(req);
    endtask

    task automatic compare_all();
        check("pending",   32'(pending),   32'(m_pend));
        check("irq_valid", 32'(irq_valid), 32'(m_valid));
        check("irq_id",    32'(irq_id),    32'(m_id));
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    initial begin
        rst_n = 1'b0; req = '0; mask_wr = 1'b0; mask_in = '0; ack = 1'b0;
        model_reset();
        #12;
        check("reset_valid",   32'(irq_valid), 32'd0);
        check("reset_pending", 32'(pending),   32'd0);
        check("reset_id",      32'(irq_id),    32'd0);
        rst_n = 1'b1;

        // Single request
        mask_wr = 1'b1; mask_in = 8'h00; step(); mask_wr = 1'b0;
        req = 8'h08; step();
        check("single_pend", 32'(pending), 32'h08);
        check("single_nov",  32'(irq_valid), 32'd0);
        req = 8'h00; step();
        check("single_valid", 32'(irq_valid), 32'd1);
        check("single_id",    32'(irq_id), 32'd3);
        ack = 1'b1; step(); ack = 1'b0;
        check("single_ackp", 32'(pending), 32'h00);
        check("single_ackv", 32'(irq_valid), 32'd0);

        // Priority
        req = 8'h22; step(); req = 8'h00; step();
        check("prio_id5", 32'(irq_id), 32'd5);
        ack = 1'b1; step(); ack = 1'b0;
        check("prio_gap", 32'(irq_valid), 32'd0);
        step();
        check("prio_v1",  32'(irq_valid), 32'd1);
        check("prio_id1", 32'(irq_id), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;

        // Mask
        mask_wr = 1'b1; mask_in = 8'h80; step(); mask_wr = 1'b0;
        req = 8'h80; step(); req = 8'h00; step(); step();
        check("mask_pend", 32'(pending), 32'h80);
        check("mask_nov",  32'(irq_valid), 32'd0);
        mask_wr = 1'b1; mask_in = 8'h00; step(); mask_wr = 1'b0;
        check("mask_still", 32'(irq_valid), 32'd0);
        step();
        check("mask_id7", 32'(irq_id), 32'd7);
        check("mask_v",   32'(irq_valid), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;

        // Collision of new edge with ack
        req = 8'h04; step(); req = 8'h00; step();
        check("coll_id2", 32'(irq_id), 32'd2);
        req = 8'h04; ack = 1'b1; step(); req = 8'h00; ack = 1'b0;
        check("coll_pend", 32'(pending), 32'h04);
        check("coll_gap",  32'(irq_valid), 32'd0);
        step();
        check("coll_reissue", 32'(irq_id), 32'd2);
        check("coll_v",       32'(irq_valid), 32'd1);
        ack = 1'b1; step(); ack = 1'b0;

        // Stability under mask and higher arrival
        req = 8'h02; step(); req = 8'h00; step();
        req = 8'h40; mask_wr = 1'b1; mask_in = 8'h02; step();
        req = 8'h00; mask_wr = 1'b0; step(); step();
        check("stab_id1", 32'(irq_id), 32'd1);
        check("stab_v",   32'(irq_valid), 32'd1);
        ack = 1'b1; step(); ack = 1'b0; step();
        check("stab_id6", 32'(irq_id), 32'd6);
        ack = 1'b1; step(); ack = 1'b0;

        // Asynchronous reset mid-ISSUED, with a request held high across release
        req = 8'h01; step(); req = 8'h00; step();
        check("rst_pre_v", 32'(irq_valid), 32'd1);
        req = 8'h05; step();
        req = 8'h10;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_valid",   32'(irq_valid), 32'd0);
        check("arst_pending", 32'(pending),   32'd0);
        check("arst_id",      32'(irq_id),    32'd0);
        #3 rst_n = 1'b1;
        step();
        check("rel_edge", 32'(pending), 32'h10);
        step(); step();
        check("rel_masked", 32'(irq_valid), 32'd0);

        // Random traffic
        for (int unsigned c = 0; c < 400; c++) begin
            req     = ($urandom_range(0, 3) == 0) ? N'($urandom) : req & N'($urandom);
            ack     = ($urandom_range(0, 2) == 0);
            mask_wr = ($urandom_range(0, 7) == 0);
            mask_in = N'($urandom) & N'($urandom);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
